reg_file_mp: RTL and testbench



---
 rtl/reg_file_mp.sv | 92 +++++++++
 tb/tb_reg_file_mp.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port ID-stage register file with hardwired zero register, optional write bypass,
// a post-reset clear sequencer and a per-register pending scoreboard for the hazard unit.
module reg_file_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int ZERO_REG = DEPTH - 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    r_reg,
  output logic [NRD*WIDTH-1:0] r_data,
  output logic [NRD-1:0]       r_pend,
  input  logic [AW-1:0]        w_reg0,
  input  logic [WIDTH-1:0]     w_data0,
  input  logic                 RegWrite0,
  input  logic [AW-1:0]        w_reg1,
  input  logic [WIDTH-1:0]     w_data1,
  input  logic                 RegWrite1,
  input  logic                 claim_en,
  input  logic [AW-1:0]        claim_reg,
  output logic                 busy
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [AW-1:0] ZIDX = AW'(ZERO_REG);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state;
  logic [AW-1:0]    clr_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend;

  logic we0, we1, claim_ok;

  assign busy     = (state == CLEAR);
  assign we0      = RegWrite0 && (w_reg0 != ZIDX);
  assign we1      = RegWrite1 && (w_reg1 != ZIDX);
  assign claim_ok = claim_en && (claim_reg != ZIDX);

  // Port 1 is written after port 0 so it wins on a shared index; likewise a
  // claim is applied after write-clears so a newer in-flight producer keeps pend set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      pend    <= '0;
    end else if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
      clr_cnt      <= clr_cnt + AW'(1);
      if (clr_cnt == LAST)
        state <= READY;
    end else begin
      if (we0)
        mem[w_reg0] <= w_data0;
      if (we1)
        mem[w_reg1] <= w_data1;
      if (we0)
        pend[w_reg0] <= 1'b0;
      if (we1)
        pend[w_reg1] <= 1'b0;
      if (claim_ok)
        pend[claim_reg] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] fwd;
    logic             masked;

    assign idx    = r_reg[k*AW +: AW];
    assign masked = busy || (idx == ZIDX);

    always_comb begin
      fwd = mem[idx];
      if (BYPASS != 0) begin
        if (RegWrite0 && (w_reg0 == idx))
          fwd = w_data0;
        if (RegWrite1 && (w_reg1 == idx))
          fwd = w_data1;
      end
    end

    assign r_data[k*WIDTH +: WIDTH] = masked ? '0 : fwd;
    assign r_pend[k]                = masked ? 1'b0 : pend[idx];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_reg_file_mp;

  localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;

  logic         clk;
  logic         rst;
  logic [9:0]   r_reg;
  logic [127:0] r_data, r_data_nb;
  logic [1:0]   r_pend, r_pend_nb;
  logic [4:0]   w_reg0, w_reg1, claim_reg;
  logic [63:0]  w_data0, w_data1;
  logic         RegWrite0, RegWrite1, claim_en;
  logic         busy, busy_nb;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic        rw0;
    logic [4:0]  wr0;
    logic [63:0] wd0;
    logic        rw1;
    logic [4:0]  wr1;
    logic [63:0] wd1;
    logic        cl;
    logic [4:0]  creg;
    logic [4:0]  rr0;
    logic [4:0]  rr1;
    logic [63:0] bd0;
    logic [63:0] bd1;
    logic [63:0] nd0;
    logic [63:0] nd1;
    logic        p0;
    logic        p1;
  } vec_t;

  vec_t vecs[14];

  reg_file_mp #(.WIDTH(64), .DEPTH(32), .NRD(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .r_reg(r_reg), .r_data(r_data), .r_pend(r_pend),
    .w_reg0(w_reg0), .w_data0(w_data0), .RegWrite0(RegWrite0),
    .w_reg1(w_reg1), .w_data1(w_data1), .RegWrite1(RegWrite1),
    .claim_en(claim_en), .claim_reg(claim_reg), .busy(busy)
  );

  reg_file_mp #(.WIDTH(64), .DEPTH(32), .NRD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .r_reg(r_reg), .r_data(r_data_nb), .r_pend(r_pend_nb),
    .w_reg0(w_reg0), .w_data0(w_data0), .RegWrite0(RegWrite0),
    .w_reg1(w_reg1), .w_data1(w_data1), .RegWrite1(RegWrite1),
    .claim_en(claim_en), .claim_reg(claim_reg), .busy(busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    RegWrite0 = v.rw0; w_reg0 = v.wr0; w_data0 = v.wd0;
    RegWrite1 = v.rw1; w_reg1 = v.wr1; w_data1 = v.wd1;
    claim_en  = v.cl;  claim_reg = v.creg;
    r_reg     = {v.rr1, v.rr0};
  endtask

  task automatic setIdle();
    RegWrite0 = 1'b0; w_reg0 = 5'd0; w_data0 = 64'd0;
    RegWrite1 = 1'b0; w_reg1 = 5'd0; w_data1 = 64'd0;
    claim_en  = 1'b0; claim_reg = 5'd0;
  endtask

  // Runs a full clear: both instances stay busy for 32 cycles with zeroed outputs,
  // while writes and claims aimed at X4/X5/X9 must be dropped.
  task automatic checkClear(input string tag);
    for (int i = 0; i < 32; i++) begin
      RegWrite0 = 1'b1; w_reg0 = 5'd5; w_data0 = 64'h77;
      RegWrite1 = 1'b1; w_reg1 = 5'd4; w_data1 = 64'h88;
      claim_en  = 1'b1; claim_reg = 5'd9;
      r_reg     = {5'd4, 5'd5};
      #1;
      checkOutput($sformatf("%s.busy%0d", tag, i), 64'(busy), 64'd1);
      checkOutput($sformatf("%s.busynb%0d", tag, i), 64'(busy_nb), 64'd1);
      checkOutput($sformatf("%s.rdata%0d", tag, i), r_data[63:0] | r_data[127:64], 64'd0);
      checkOutput($sformatf("%s.rpend%0d", tag, i), 64'(r_pend), 64'd0);
      tick();
    end
    setIdle();
    r_reg = {5'd30, 5'd5};
    #1;
    checkOutput({tag, ".busy_end"}, 64'(busy), 64'd0);
    checkOutput({tag, ".x5"}, r_data[63:0], 64'd0);
    checkOutput({tag, ".x30"}, r_data[127:64], 64'd0);
    r_reg = {5'd9, 5'd4};
    #1;
    checkOutput({tag, ".x4"}, r_data[63:0], 64'd0);
    checkOutput({tag, ".x9"}, r_data[127:64], 64'd0);
    checkOutput({tag, ".x4nb"}, r_data_nb[63:0], 64'd0);
    checkOutput({tag, ".pend"}, 64'(r_pend), 64'd0);
  endtask

  initial begin
    //            rw0  wr0    wd0             rw1  wr1    wd1         cl   creg   rr0    rr1    bd0          bd1          nd0          nd1          p0    p1
    vecs[0]  = '{1'b1, 5'd3,  DB,            1'b0, 5'd0,  64'h0,     1'b0, 5'd0,  5'd3,  5'd7,  DB,          64'h0,       64'h0,       64'h0,       1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,     1'b0, 5'd0,  5'd3,  5'd3,  DB,          DB,          DB,          DB,          1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd7,  64'h11,        1'b1, 5'd7,  64'h22,    1'b0, 5'd0,  5'd3,  5'd7,  DB,          64'h22,      DB,          64'h0,       1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,     1'b0, 5'd0,  5'd7,  5'd7,  64'h22,      64'h22,      64'h22,      64'h22,      1'b0, 1'b0};
    vecs[4]  = '{1'b1, 5'd31, 64'hFFFF,      1'b0, 5'd0,  64'h0,     1'b1, 5'd31, 5'd31, 5'd31, 64'h0,       64'h0,       64'h0,       64'h0,       1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,     1'b1, 5'd9,  5'd31, 5'd9,  64'h0,       64'h0,       64'h0,       64'h0,       1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  64'h0,         1'b1, 5'd9,  64'h99,    1'b1, 5'd9,  5'd9,  5'd31, 64'h99,      64'h0,       64'h0,       64'h0,       1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'd9,  64'hAA,        1'b0, 5'd0,  64'h0,     1'b0, 5'd0,  5'd9,  5'd9,  64'hAA,      64'hAA,      64'h99,      64'h99,      1'b1, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,     1'b0, 5'd0,  5'd9,  5'd3,  64'hAA,      DB,          64'hAA,      DB,          1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd3,  64'h123,       1'b1, 5'd5,  64'h456,   1'b0, 5'd0,  5'd5,  5'd3,  64'h456,     64'h123,     64'h0,       DB,          1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'd4,  64'h55,        1'b0, 5'd0,  64'h0,     1'b1, 5'd4,  5'd4,  5'd5,  64'h55,      64'h456,     64'h0,       64'h456,     1'b0, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,     1'b0, 5'd0,  5'd4,  5'd4,  64'h55,      64'h55,      64'h55,      64'h55,      1'b1, 1'b1};
    vecs[12] = '{1'b0, 5'd0,  64'h0,         1'b1, 5'd4,  64'h55,    1'b0, 5'd0,  5'd4,  5'd9,  64'h55,      64'hAA,      64'h55,      64'hAA,      1'b1, 1'b0};
    vecs[13] = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,     1'b1, 5'd6,  5'd4,  5'd0,  64'h55,      64'h0,       64'h55,      64'h0,       1'b0, 1'b0};

    rst = 1'b1;
    setIdle();
    r_reg = {5'd30, 5'd5};
    tick();
    tick();
    checkOutput("reset.busy", 64'(busy), 64'd1);
    checkOutput("reset.rdata", r_data[63:0] | r_data[127:64], 64'd0);
    rst = 1'b0;
    checkClear("clear1");

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d.busy", i), 64'(busy), 64'd0);
      checkOutput($sformatf("v%0d.bd0", i), r_data[63:0], vecs[i].bd0);
      checkOutput($sformatf("v%0d.bd1", i), r_data[127:64], vecs[i].bd1);
      checkOutput($sformatf("v%0d.nd0", i), r_data_nb[63:0], vecs[i].nd0);
      checkOutput($sformatf("v%0d.nd1", i), r_data_nb[127:64], vecs[i].nd1);
      checkOutput($sformatf("v%0d.p0", i), 64'(r_pend[0]), 64'(vecs[i].p0));
      checkOutput($sformatf("v%0d.p1", i), 64'(r_pend[1]), 64'(vecs[i].p1));
      checkOutput($sformatf("v%0d.pnb", i), 64'(r_pend_nb), 64'({vecs[i].p1, vecs[i].p0}));
      tick();
    end

    setIdle();
    r_reg = {5'd31, 5'd6};
    #1;
    checkOutput("pre_rst.pend6", 64'(r_pend), 64'd1);
    checkOutput("pre_rst.x31", r_data[127:64], 64'd0);

    // Restart the clear part-way through; a missing restart would drop busy after 22 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput($sformatf("partial.busy%0d", i), 64'(busy), 64'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkClear("clear2");
    r_reg = {5'd4, 5'd6};
    #1;
    checkOutput("clear2.pend6", 64'(r_pend), 64'd0);
    checkOutput("clear2.pend6nb", 64'(r_pend_nb), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
